// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one of four requesters onto a shared DW-bit mux output.
// Optional macro ARB_HOLD_LIMIT_EN caps grant tenure at MAX_HOLD cycles under competition.
module mux_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            gnt_valid,
    output logic [DW-1:0]   out_data
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_r;
    logic [1:0]  ptr_r;
    logic [3:0]  gnt_r;
    logic [1:0]  sel_r;
    logic        gnt_valid_r;
    logic [1:0]  next_ptr_s;
    logic [2:0]  pick_ptr_s;
    logic [2:0]  pick_rel_s;
    logic [DW-1:0] out_data_s;

    // Returns {found, index} of the first set request scanning from p upward with wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + k[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign next_ptr_s = sel_r + 2'd1;
    assign pick_ptr_s = rr_pick(req, ptr_r);
    assign pick_rel_s = rr_pick(req, next_ptr_s);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_r;
    logic       others_s;

    // Owner itself is excluded so only genuine competitors can trigger preemption.
    assign others_s = |(req & ~gnt_r);
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^8'(MAX_HOLD);
`endif

    // Arbitration FSM: grant, hold, hand-over on release and (optionally) preemption.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'b00;
            gnt_r       <= 4'b0000;
            sel_r       <= 2'b00;
            gnt_valid_r <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r  <= 8'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_ptr_s[2]) begin
                        state_r     <= GRANT;
                        gnt_r       <= 4'b0001 << pick_ptr_s[1:0];
                        sel_r       <= pick_ptr_s[1:0];
                        gnt_valid_r <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt_r  <= 8'd0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (req[sel_r]) begin
`ifdef ARB_HOLD_LIMIT_EN
                        if (hold_cnt_r == HOLD_LAST) begin
                            hold_cnt_r <= 8'd0;
                            if (others_s) begin
                                ptr_r <= next_ptr_s;
                                gnt_r <= 4'b0001 << pick_rel_s[1:0];
                                sel_r <= pick_rel_s[1:0];
                            end else begin
                                ptr_r <= ptr_r;
                            end
                        end else if (hold_cnt_r != 8'hFF) begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`else
                        state_r <= GRANT;
`endif
                    end else begin
                        // Release: the old owner drops to lowest priority for the next pick.
                        ptr_r <= next_ptr_s;
                        if (pick_rel_s[2]) begin
                            gnt_r       <= 4'b0001 << pick_rel_s[1:0];
                            sel_r       <= pick_rel_s[1:0];
`ifdef ARB_HOLD_LIMIT_EN
                            hold_cnt_r  <= 8'd0;
`endif
                        end else begin
                            state_r     <= IDLE;
                            gnt_r       <= 4'b0000;
                            gnt_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_r       <= 4'b0000;
                    gnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Shared mux output: the granted word, forced to zero while idle.
    always_comb begin
        out_data_s = {DW{1'b0}};
        if (gnt_valid_r) begin
            out_data_s = in_data[sel_r*DW +: DW];
        end else begin
            out_data_s = {DW{1'b0}};
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign gnt_valid = gnt_valid_r;
    assign out_data  = out_data_s;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] in_data;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            gnt_valid;
    logic [DW-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index or -1 when idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;

    mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mpick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update();
        int nxt;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            nxt = mpick(req, m_ptr);
            if (nxt >= 0) begin
                m_owner = nxt; m_sel = nxt; m_hold = 0;
            end
        end else if (req[m_owner]) begin
            if (HOLD_EN && m_hold == MAX_HOLD - 1) begin
                m_hold = 0;
                if ((req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = mpick(req, m_ptr);
                    m_sel   = m_owner;
                end
            end else if (m_hold < 255) begin
                m_hold = m_hold + 1;
            end
        end else begin
            m_ptr = (m_owner + 1) % 4;
            nxt = mpick(req, m_ptr);
            m_owner = nxt;
            if (nxt >= 0) begin
                m_sel = nxt; m_hold = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (gnt !== 4'b0000 || sel !== 2'b00 || gnt_valid !== 1'b0 || out_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: gnt=%b sel=%b gv=%b out=%h, want 0000/00/0/00",
                         c, gnt, sel, gnt_valid, out_data);
            end
            tick();
        end
    endtask

    task automatic test_single();
        reset_dut();
        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b0100;
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (gnt !== 4'b0100 || sel !== 2'b10 || gnt_valid !== 1'b1 || out_data !== 8'hC2) begin
                errors++;
                $display("FAIL single_grant cyc %0d: gnt=%b sel=%b gv=%b out=%h, want 0100/10/1/c2",
                         c, gnt, sel, gnt_valid, out_data);
            end
            tick();
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'b10 || gnt_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL single_release: gnt=%b sel=%b gv=%b out=%h, want 0000/10/0/00",
                     gnt, sel, gnt_valid, out_data);
        end
    endtask

    task automatic test_rotation();
        int order[5] = '{0, 1, 2, 3, 0};
        reset_dut();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int h = 0; h < 2; h++) begin
                checks++;
                if (gnt !== (4'b0001 << order[k]) || sel !== 2'(order[k]) || gnt_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rotation step %0d hold %0d: gnt=%b sel=%b gv=%b, want owner %0d",
                             k, h, gnt, sel, gnt_valid, order[k]);
                end
                if (h == 1) req[order[k]] = 1'b0;
                tick();
            end
            req = 4'b1111;
        end
    endtask

    task automatic test_ptr_wrap();
        reset_dut();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'b11) begin
            errors++;
            $display("FAIL wrap_owner3: gnt=%b sel=%b, want 1000/11", gnt, sel);
        end
        req = 4'b0000;
        tick();
        req = 4'b1010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'b01) begin
            errors++;
            $display("FAIL wrap_idx1_first: gnt=%b sel=%b, want 0010/01", gnt, sel);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'b11 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_then3: gnt=%b sel=%b gv=%b, want 1000/11/1", gnt, sel, gnt_valid);
        end
    endtask

    task automatic test_hold();
        logic [3:0] want;
        reset_dut();
        req = 4'b0011;
        tick();
        for (int c = 0; c < 16; c++) begin
`ifdef ARB_HOLD_LIMIT_EN
            want = (((c / MAX_HOLD) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
            want = 4'b0001;
`endif
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("FAIL hold_pattern cyc %0d: gnt=%b, want %b", c, gnt, want);
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        reset_dut();
        req = 4'b0100;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || gnt_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_clear: gnt=%b sel=%b gv=%b out=%h, want 0000/00/0/00",
                     gnt, sel, gnt_valid, out_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'b10 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_regrant: gnt=%b sel=%b gv=%b, want 0100/10/1", gnt, sel, gnt_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0]    exp_gnt;
        logic [DW-1:0] exp_out;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 49) == 0);
            in_data = $urandom;
            tick();
            exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            exp_out = (m_owner < 0) ? 8'h00 : in_data[m_owner*DW +: DW];
            checks++;
            if (gnt !== exp_gnt || sel !== 2'(m_sel) || gnt_valid !== (m_owner >= 0) || out_data !== exp_out) begin
                errors++;
                $display("FAIL random cyc %0d: gnt=%b sel=%b gv=%b out=%h, want %b/%0d/%0d/%h",
                         c, gnt, sel, gnt_valid, out_data, exp_gnt, m_sel, (m_owner >= 0), exp_out);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        in_data = '0;
        test_reset();
        test_single();
        test_rotation();
        test_ptr_wrap();
        test_hold();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 data multiplexer among 4 requesters.
- Registers a one-hot grant and the matching 2-bit select.
- Steers the granted requester's data word onto a single shared output.
- Sits in front of the shared 4:1 mux datapath, replacing a static/software-driven sel with hardware sequencing.

Parameters:
- DW, 8, data width of each requester's word.
- MAX_HOLD, 4, max consecutive grant cycles for one owner while others wait (used only with the optional feature); legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  4  request vector; req[i] high = requester i wants the mux.
- in_data  input  4*DW  packed words; requester i at in_data[i*DW +: DW].
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered select = index of gnt bit; holds last owner when idle.
- gnt_valid  output  1  registered; high while any gnt bit is set.
- out_data  output  DW  combinational; in_data[sel*DW +: DW] when gnt_valid, else 0.

Behaviour:
- Reset values (rst sampled high at posedge):
  - state=IDLE, gnt=4'b0000, sel=2'b00, gnt_valid=0, ptr=2'b00, hold_cnt=0.
  - out_data therefore 0.
  - rst has priority over all other inputs.
- Internal state:
  - ptr (2b): highest-priority index for the next pick.
  - hold_cnt (8b).
  - FSM states: IDLE, GRANT.
- Pick function: first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrap 3->0) with req[i]=1.
- IDLE:
  - If req != 0: go to GRANT at next edge with gnt=onehot(pick), sel=pick, gnt_valid=1, hold_cnt=0.
  - Latency is exactly 1 cycle from req sampled to gnt visible.
  - If req == 0: stay IDLE; sel keeps its old value.
- GRANT, owner o, req[o]=1:
  - Hold the grant; hold_cnt saturates at 255.
  - Preemption only with the optional feature.
- GRANT, owner o, req[o]=0 (release):
  - ptr <= o+1.
  - If any other req is set, switch directly at the next edge to pick(ptr=o+1) with no idle bubble; hold_cnt=0.
  - Otherwise go to IDLE: gnt=0, gnt_valid=0.
- Simultaneous requests: the pick function decides. After owner i releases, i has lowest priority next round, which guarantees fairness.
- A requester that drops req before being granted is simply not picked; no latching of requests.
- Requester re-asserting in the same cycle it is released: treated as a new request under the new ptr.
- Mid-operation reset: grant is withdrawn at that edge and all state returns to reset values.
- gnt is always one-hot or zero; sel always equals the encoded gnt while gnt_valid=1.

Optional Feature:
Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - In GRANT with req[o]=1, hold_cnt increments each cycle.
  - When hold_cnt == MAX_HOLD-1 and some other req[j]=1 (j!=o), preempt at the next edge: ptr <= o+1, grant pick(o+1), hold_cnt=0.
  - If no other requester is pending, the owner keeps the grant and hold_cnt resets to 0.
  - With continuous competition, max grant tenure is therefore MAX_HOLD cycles.
- Not defined: hold_cnt logic is compiled out and an owner keeps the grant until it drops req.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0000, sel=00, gnt_valid=0, out_data=0 throughout.
- in_data={8'hD3,8'hC2,8'hB1,8'hA0}, req=4'b0100 held -> 1 cycle later gnt=0100, sel=10, gnt_valid=1, out_data=8'hC2; drop req -> next cycle gnt=0000, gnt_valid=0, out_data=0.
- From reset, req=4'b1111, each owner drops req 2 cycles after its grant -> grant order 0,1,2,3,0 with no idle cycles between owners; sel sequence 00,01,10,11,00.
- Owner 3 granted, ptr after release=0, then req=4'b1010 -> gnt=0010 (index 1 beats 3); after 1 releases, gnt=1000.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4, req=4'b0011 held constant -> gnt alternates 0001 x4 cycles, 0010 x4 cycles, repeating. Without the macro -> gnt=0001 indefinitely.
- rst pulsed 1 cycle while gnt=0100 -> next edge gnt=0000, sel=00, gnt_valid=0. With req still 0100 -> regranted 1 cycle after rst deasserts.
